// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, operand width defaults and the result function.
// alu_compute works at XLEN_MAX bits; narrower users zero-extend operands and truncate the result.
package alu_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int XLEN_MAX     = 64;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_AND = 4'b0000;
    localparam opcode_t OP_OR  = 4'b0001;
    localparam opcode_t OP_ADD = 4'b0010;
    localparam opcode_t OP_SUB = 4'b0110;
    localparam opcode_t OP_SLT = 4'b0111;
    localparam opcode_t OP_NOR = 4'b1100;

    typedef struct packed {
        logic [XLEN_MAX-1:0] result;
        logic                err;
    } alu_out_t;

    // Unsupported opcodes return zero with err set; the caller still delivers them.
    function automatic alu_out_t alu_compute(input opcode_t op,
                                             input logic [XLEN_MAX-1:0] a,
                                             input logic [XLEN_MAX-1:0] b);
        alu_out_t o;
        o.result = '0;
        o.err    = 1'b0;
        case (op)
            OP_AND:  o.result = a & b;
            OP_OR:   o.result = a | b;
            OP_ADD:  o.result = a + b;
            OP_SUB:  o.result = a - b;
            OP_SLT:  o.result = {{(XLEN_MAX-1){1'b0}}, (a < b)};
            OP_NOR:  o.result = ~(a | b);
            default: o.err    = 1'b1;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from valid bits and a priority pointer.
// The pointer moves to the other requester whenever the granted request is accepted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        // NOTE: default assigned first so no path through the case leaves grant unassigned (no latch).
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values regardless of block order.
        if (rst)
            ptr <= 1'b0;
        else if (advance)
            ptr <= grant[0];
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU through a round-robin arbiter and a single-entry result stage.
// Supports XLEN up to alu_pkg::XLEN_MAX; NREQ must stay at 2.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [4*NREQ-1:0]    req_op,
    input  logic [NREQ*XLEN-1:0] req_a,
    input  logic [NREQ*XLEN-1:0] req_b,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [XLEN-1:0]      resp_result,
    output logic                 resp_zero,
    output logic                 resp_err
);

    logic [1:0]      grant;
    logic            stage_valid;
    logic            stage_owner;
    logic [XLEN-1:0] stage_result;
    logic            stage_zero;
    logic            stage_err;
    logic            stage_free;
    logic            accept;
    logic            sel;
    opcode_t         sel_op;
    logic [XLEN-1:0] sel_a;
    logic [XLEN-1:0] sel_b;
    alu_out_t        alu_o;
    logic [XLEN-1:0] alu_result;

    // The stage can take a new operation in the same cycle its owner drains it.
    assign stage_free = !stage_valid || resp_ready[stage_owner];
    assign req_ready  = (rst || !stage_free) ? 2'b00 : grant;
    assign accept     = |req_ready;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   (req_valid),
        .advance (accept),
        .grant   (grant)
    );

    assign sel        = grant[1];
    assign sel_op     = sel ? req_op[7:4] : req_op[3:0];
    assign sel_a      = sel ? req_a[2*XLEN-1:XLEN] : req_a[XLEN-1:0];
    assign sel_b      = sel ? req_b[2*XLEN-1:XLEN] : req_b[XLEN-1:0];
    assign alu_o      = alu_compute(sel_op, XLEN_MAX'(sel_a), XLEN_MAX'(sel_b));
    assign alu_result = alu_o.result[XLEN-1:0];

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the data fields are reset too, because the result outputs must read zero during reset.
        if (rst) begin
            stage_valid  <= 1'b0;
            stage_owner  <= 1'b0;
            stage_result <= '0;
            stage_zero   <= 1'b0;
            stage_err    <= 1'b0;
        end else if (accept) begin
            stage_valid  <= 1'b1;
            stage_owner  <= sel;
            stage_result <= alu_result;
            stage_zero   <= (alu_result == '0);
            stage_err    <= alu_o.err;
        end else if (stage_valid && resp_ready[stage_owner]) begin
            stage_valid  <= 1'b0;
        end
    end

    always_comb begin
        resp_valid = 2'b00;
        if (stage_valid)
            resp_valid[stage_owner] = 1'b1;
    end

    assign resp_result = stage_result;
    assign resp_zero   = stage_zero;
    assign resp_err    = stage_err;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter XLEN, default 64, operand and result width.
REQ-002 Parameter NREQ, fixed at 2, number of requesters; other values are not supported.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  2  bit i: requester i presents an operation.
REQ-006 req_ready  output  2  bit i: operation of requester i is accepted this cycle.
REQ-007 req_op  input  2x4  ALU opcode per requester, packed with requester i in bits [4i+3:4i].
REQ-008 req_a  input  2xXLEN  first operand per requester, packed.
REQ-009 req_b  input  2xXLEN  second operand per requester, packed.
REQ-010 resp_valid  output  2  bit i: the result stage holds a result owned by requester i.
REQ-011 resp_ready  input  2  bit i: requester i consumes its result this cycle.
REQ-012 resp_result  output  XLEN  result of the held operation; meaningful only while some resp_valid bit is 1.
REQ-013 resp_zero  output  1  1 when resp_result == 0.
REQ-014 resp_err  output  1  1 when the held operation had an unsupported opcode.

Function
REQ-015 Opcodes and results:
- 0000 = AND.
- 0001 = OR.
- 0010 = ADD, mod 2^XLEN.
- 0110 = SUB, a-b mod 2^XLEN.
- 0111 = SLT, unsigned compare, result 1 if a<b else 0, zero-extended.
- 1100 = NOR.
REQ-016 Any other opcode yields result 0, resp_err=1 and resp_zero=1; it is still accepted and returned as a normal response.
REQ-017 A single result stage holds at most one operation: {valid, owner, result, zero, err}.
REQ-018 The stage is free when it is empty, or when it is full and the owner's resp_ready is 1 in that cycle (same-cycle drain and refill).
REQ-019 At most one req_ready bit is 1 per cycle; req_ready[i] = stage free AND grant[i].
REQ-020 The grant is combinational from req_valid and the priority pointer ptr:
- If only requester i is valid, it is granted.
- If both are valid, requester ptr is granted.
- If neither is valid, there is no grant.
REQ-021 On acceptance (req_valid[i] & req_ready[i]) ptr becomes 1-i; otherwise ptr holds its value.
REQ-022 Latency is 1 cycle: an operation accepted at edge N appears with resp_valid[owner]=1 immediately after edge N.
REQ-023 Throughput is 1 operation per cycle when resp_ready is held at 1.
REQ-024 Only resp_valid[owner] may be 1; the other bit is 0.
REQ-025 While resp_valid[owner]=1 and resp_ready[owner]=0, resp_result, resp_zero and resp_err are held stable.
REQ-026 A stage that drains with no new acceptance becomes empty on that edge.
REQ-027 req_* inputs of a non-accepted requester are ignored; requesters hold their request until accepted, and the arbiter is not required to tolerate withdrawal.
REQ-028 resp_ready[j] for the non-owner j has no effect.
REQ-029 req_ready depends combinationally on resp_ready and req_valid only; there is no path from req_op, req_a or req_b to req_ready.

Reset
REQ-030 While rst=1: stage empty, resp_valid=00, req_ready=00, resp_result=0, resp_zero=0, resp_err=0, ptr=0.
REQ-031 Assertion of rst mid-operation discards the held result without delivering it.
REQ-032 The first acceptance can occur on the first rising edge after rst deasserts.

Structure
REQ-033 A shared package alu_pkg holds:
- the opcode constants from REQ-015;
- the 4-bit opcode typedef;
- XLEN default;
- a function computing {result, err} from (op, a, b).
REQ-034 One sub-module, rr_arb2, implements the two-way round-robin grant and ptr register; operand muxing and the result stage stay in alu_arbiter.

Verification
REQ-035 Reset, then requester 0 sends ADD a=5, b=7 with resp_ready=1 -> resp_valid=01 one cycle later, resp_result=12, resp_zero=0.
REQ-036 Both requesters valid continuously, resp_ready=11, after reset -> grants alternate 0,1,0,1; four results are returned back-to-back on consecutive cycles.
REQ-037 Requester 1 sends SUB a=3, b=3 with resp_ready[1]=0 for 3 cycles -> result 0 and resp_zero=1 held stable; req_ready=00 throughout; acceptance resumes in the cycle resp_ready[1]=1.
REQ-038 Edge values:
- SLT a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> 0.
- ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> 0 with resp_zero=1.
- Opcode 1111 -> resp_err=1, result 0.
REQ-039 Full stage with rst asserted asynchronously between edges -> resp_valid drops to 00 immediately; after release, ptr=0 grants requester 0 first when both are valid.
